mult_seq_param: RTL and testbench

//  Parametrised iterative shift-add multiplier. Next generation of our 16x8 sequential

---
 rtl/mult_pkg.sv | 33 +++
 rtl/mult_pp_gen.sv | 13 +
 rtl/mult_seq_param.sv | 106 ++++++++++
 tb/tb_mult_seq_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WORK = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    while ((64'(1) << res) < 64'(val)) res++;
    return res;
  endfunction

  // True when the digit width is legal for the given multiplier width.
  function automatic bit k_divides(input int unsigned b_w, input int unsigned k);
    if (k == 0) return 1'b0;
    return (b_w % k) == 0;
  endfunction

  // Magnitude of a w-bit value held in the low bits of x; two's complement only when en.
  function automatic logic [63:0] abs_w(input logic [63:0] x, input int unsigned w,
                                        input logic en);
    logic [63:0] mask;
    logic [63:0] top;
    mask = (64'(1) << w) - 64'(1);
    top  = x >> (w - 1);
    if (en && top[0]) return ((~x) + 64'(1)) & mask;
    return x & mask;
  endfunction

endpackage

// File: rtl/mult_pp_gen.sv
// Combinational A_W x K partial product for one multiplier digit.
module mult_pp_gen #(
  parameter int unsigned A_W = 16,
  parameter int unsigned K   = 1
) (
  input  logic [A_W-1:0]   mag_a,
  input  logic [K-1:0]     digit,
  output logic [A_W+K-1:0] pp_c
);

  assign pp_c = (A_W + K)'(mag_a) * (A_W + K)'(digit);

endmodule

// File: rtl/mult_seq_param.sv
// Iterative radix-2^K shift-add multiplier on magnitudes, sign applied at completion.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int unsigned A_W        = 16,
  parameter int unsigned B_W        = 8,
  parameter int unsigned K          = 1,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [A_W-1:0]     a_bi,
  input  logic [B_W-1:0]     b_bi,
  output logic               busy_o,
  output logic               done_o,
  output logic [A_W+B_W-1:0] y_bo
);

  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned PP_W  = A_W + K;
  localparam int unsigned STEPS = B_W / K;
  localparam int unsigned CTR_W = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);

  if (!k_divides(B_W, K) || (A_W < 2) || (B_W < 2)) begin : g_bad_param
    $error("mult_seq_param: K must divide B_W and operand widths must be >= 2");
  end

  state_e           state_q;
  logic [A_W-1:0]   mag_a_q;
  logic [B_W-1:0]   mag_b_q;
  logic             neg_q;
  logic [P_W-1:0]   acc_q;
  logic [CTR_W-1:0] ctr_q;

  logic [PP_W-1:0]  pp_c;
  logic [P_W-1:0]   sum_c;
  logic [P_W-1:0]   res_c;
  logic [B_W-1:0]   b_rest_c;
  logic             last_c;
  logic [A_W-1:0]   mag_a_c;
  logic [B_W-1:0]   mag_b_c;

  mult_pp_gen #(
    .A_W (A_W),
    .K   (K)
  ) u_pp_gen (
    .mag_a (mag_a_q),
    .digit (mag_b_q[K-1:0]),
    .pp_c  (pp_c)
  );

  // Operand magnitudes latched at start; unsigned widths cover the most negative value.
  assign mag_a_c = A_W'(abs_w(64'(a_bi), A_W, signed_i));
  assign mag_b_c = B_W'(abs_w(64'(b_bi), B_W, signed_i));

  always_comb begin
    sum_c    = acc_q + (P_W'(pp_c) << (32'(ctr_q) * K));
    b_rest_c = mag_b_q >> K;
    last_c   = (ctr_q == CTR_W'(STEPS - 1)) || (EARLY_EXIT && (b_rest_c == '0));
    res_c    = neg_q ? ((~sum_c) + P_W'(1)) : sum_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      ctr_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      y_bo    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_WORK;
            busy_o  <= 1'b1;
            mag_a_q <= mag_a_c;
            mag_b_q <= mag_b_c;
            neg_q   <= signed_i & (a_bi[A_W-1] ^ b_bi[B_W-1]);
            acc_q   <= '0;
            ctr_q   <= '0;
          end
        end
        ST_WORK: begin
          acc_q   <= sum_c;
          mag_b_q <= b_rest_c;
          ctr_q   <= ctr_q + CTR_W'(1);
          if (last_c) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            y_bo    <= res_c;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench: three multiplier configurations checked against directed and modelled products.
module tb_mult_seq_param;

  localparam int unsigned A_W   = 16;
  localparam int unsigned B_W   = 8;
  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned N_DUT = 3;

  typedef struct {
    logic [P_W-1:0] y;
    int unsigned    lat;
    int unsigned    t0;
  } exp_t;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           st   [N_DUT];
  logic           sg   [N_DUT];
  logic [A_W-1:0] a    [N_DUT];
  logic [B_W-1:0] b    [N_DUT];
  logic           busy [N_DUT];
  logic           done [N_DUT];
  logic [P_W-1:0] y    [N_DUT];

  exp_t        q [N_DUT][$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: K=1 full latency, u1: K=1 early exit, u2: K=2
  mult_seq_param #(.A_W(A_W), .B_W(B_W), .K(1), .EARLY_EXIT(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[0]), .signed_i(sg[0]), .a_bi(a[0]), .b_bi(b[0]),
    .busy_o(busy[0]), .done_o(done[0]), .y_bo(y[0]));
  mult_seq_param #(.A_W(A_W), .B_W(B_W), .K(1), .EARLY_EXIT(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[1]), .signed_i(sg[1]), .a_bi(a[1]), .b_bi(b[1]),
    .busy_o(busy[1]), .done_o(done[1]), .y_bo(y[1]));
  mult_seq_param #(.A_W(A_W), .B_W(B_W), .K(2), .EARLY_EXIT(1'b0)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[2]), .signed_i(sg[2]), .a_bi(a[2]), .b_bi(b[2]),
    .busy_o(busy[2]), .done_o(done[2]), .y_bo(y[2]));

  task automatic check(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [P_W-1:0] ref_mul(input bit sgn, input logic [A_W-1:0] av,
                                             input logic [B_W-1:0] bv);
    longint pa, pb;
    pa = sgn ? longint'($signed(av)) : longint'(av);
    pb = sgn ? longint'($signed(bv)) : longint'(bv);
    return P_W'(pa * pb);
  endfunction

  // Monitors: every done pulse must match the oldest expectation, value and latency.
  for (genvar g = 0; g < N_DUT; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (done[g] === 1'b1) begin
        if (q[g].size() == 0) begin
          check($sformatf("spurious_done_u%0d", g), P_W'(done[g]), '0);
        end else begin
          e = q[g].pop_front();
          check($sformatf("y_u%0d", g), y[g], e.y);
          check($sformatf("latency_u%0d", g), P_W'(cyc - e.t0), P_W'(e.lat));
        end
      end
    end
  end

  // Issue one operation; with hold, start stays high and operands churn during WORK.
  task automatic run(input int d, input bit sgn, input logic [A_W-1:0] av,
                     input logic [B_W-1:0] bv, input logic [P_W-1:0] ey,
                     input int unsigned lat, input bit hold);
    exp_t e;
    bit   seen;
    @(negedge clk);
    st[d] = 1'b1; sg[d] = sgn; a[d] = av; b[d] = bv;
    e.y = ey; e.lat = lat; e.t0 = cyc + 1;
    q[d].push_back(e);
    @(negedge clk);
    if (!hold) st[d] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (hold) check($sformatf("busy_hold_u%0d", d), P_W'(busy[d]), P_W'(1));
      if (hold) begin
        a[d]  = A_W'($urandom);
        b[d]  = B_W'($urandom);
        sg[d] = ~sg[d];
      end
      @(negedge clk);
    end
    check($sformatf("done_seen_u%0d", d), P_W'(seen), P_W'(1));
    check($sformatf("busy_at_done_u%0d", d), P_W'(busy[d]), '0);
    st[d] = 1'b0;
  endtask

  initial begin
    logic [A_W-1:0] ra;
    logic [B_W-1:0] rb;
    bit             rs;
    for (int i = 0; i < N_DUT; i++) begin
      st[i] = 1'b0; sg[i] = 1'b0; a[i] = '0; b[i] = '0;
    end
    #2;
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("rst_busy_u%0d", i), P_W'(busy[i]), '0);
      check($sformatf("rst_done_u%0d", i), P_W'(done[i]), '0);
      check($sformatf("rst_y_u%0d", i), y[i], '0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(0, 1'b0, 16'hFFFF, 8'hFF, 24'hFEFF01, 8, 1'b0);
    run(0, 1'b1, 16'hFFFD, 8'h05, 24'hFFFFF1, 8, 1'b0);
    run(0, 1'b1, 16'h8000, 8'h80, 24'h400000, 8, 1'b0);

    run(1, 1'b0, 16'd100,  8'h03, 24'h00012C, 2, 1'b0);
    run(1, 1'b0, 16'h1234, 8'h00, 24'h000000, 1, 1'b0);
    run(1, 1'b1, 16'hFFFD, 8'h05, 24'hFFFFF1, 3, 1'b0);
    run(1, 1'b0, 16'hFFFF, 8'hFF, 24'hFEFF01, 8, 1'b0);

    run(2, 1'b1, 16'h8000, 8'h80, 24'h400000, 4, 1'b0);
    run(2, 1'b0, 16'hFFFF, 8'hFF, 24'hFEFF01, 4, 1'b0);

    run(0, 1'b0, 16'h1234, 8'h56, 24'h061D78, 8, 1'b1);

    // Abort mid-operation: no expectation is queued, so any done would be flagged.
    @(negedge clk);
    st[0] = 1'b1; sg[0] = 1'b0; a[0] = 16'hFFFF; b[0] = 8'hFF;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", P_W'(busy[0]), P_W'(1));
    rst_n = 1'b0;
    #1;
    check("abort_busy", P_W'(busy[0]), '0);
    check("abort_done", P_W'(done[0]), '0);
    check("abort_y", y[0], '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_y_held", y[0], '0);
    run(0, 1'b1, 16'h0007, 8'hF9, 24'hFFFFCF, 8, 1'b0);

    for (int n = 0; n < 100; n++) begin
      ra = A_W'($urandom);
      rb = B_W'($urandom);
      rs = 1'($urandom);
      run(0, rs, ra, rb, ref_mul(rs, ra, rb), 8, 1'b0);
      run(2, rs, ra, rb, ref_mul(rs, ra, rb), 4, 1'b0);
    end

    repeat (4) @(negedge clk);
    for (int i = 0; i < N_DUT; i++)
      check($sformatf("queue_empty_u%0d", i), P_W'(q[i].size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
